rx_huge_pages_addr_n: RTL and testbench
=======================================

Name: rx_huge_pages_addr_n

Overview:
Parametrised successor to the two-page huge-page address receiver. It sits on the PCIe TRN RX path as a passive snooper, in parallel with the other BAR-2 register decoders. It decodes host MWr32/MWr64 TLPs to BAR_HIT. From them it captures a 64-bit, byte-swapped huge-page bus address for each of NUM_PAGES pages, and per-page unlock (page ready) doorbells. It adds length checking, drain-to-EOF, discontinue abort and atomic address commit.

Parameters:
NUM_PAGES, 2, number of huge pages (1..8)
BAR_HIT, 2, index into trn_rbar_hit_n decoded by this block
ADDR_BASE_DW, 16, dword offset (addr[7:2]) of page 0 address low DW; page k at ADDR_BASE_DW+2k
UNLOCK_BASE_DW, 24, dword offset of page 0 unlock doorbell; page k at UNLOCK_BASE_DW+k

Ports:
trn_clk  in  1  TRN clock
reset  in  1  asynchronous, active-high reset
trn_rd  in  64  RX data
trn_rrem_n  in  8  RX remainder (unused; length field is authoritative)
trn_rsof_n  in  1  start of frame, active low
trn_reof_n  in  1  end of frame, active low
trn_rsrc_rdy_n  in  1  source ready, active low
trn_rsrc_dsc_n  in  1  source discontinue, active low
trn_rbar_hit_n  in  7  BAR hit, active low
trn_rdst_rdy_n  in  1  destination ready (driven elsewhere), active low
huge_page_addr  out  64*NUM_PAGES  page k address at [64k+63:64k]
huge_page_status  out  NUM_PAGES  1 = page owned by hardware (unlocked, ready)
huge_page_free  in  NUM_PAGES  1-cycle pulse: consumer releases page k
unlock_err  out  1  1-cycle pulse: unlock for a page already in status 1

Behaviour:
- Reset is asynchronous. It clears huge_page_addr, huge_page_status, unlock_err and the shadow registers, and puts the FSM in IDLE. Reset mid-TLP discards the TLP.
- A beat is valid when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0. Non-valid cycles hold all state.
- FSM states: IDLE, H32, H64, D32, D64, DRAIN.
- IDLE: on a valid SOF beat with trn_rbar_hit_n[BAR_HIT]=0:
  - fmt/type trn_rd[62:56]=7'h40 → H32.
  - 7'h60 → H64.
  - Any other type with trn_reof_n=1 → DRAIN.
  - Latch length = trn_rd[41:32].
- H32 (beat 2): dword index = trn_rd[39:34]; shadow_lo ← trn_rd[31:0].
- H64 (beat 2): dword index = trn_rd[7:2].
- Decode, with k the decoded page, k < NUM_PAGES:
  - index == ADDR_BASE_DW+2k and length==2 → D32 or D64, recording k.
  - index == UNLOCK_BASE_DW+k and length>=1 → set pending unlock for page k.
  - Anything else → no action.
- From H32/H64 on any unlock or no-match: go to IDLE if EOF is on this beat, otherwise DRAIN.
- Unlock is committed on the valid EOF beat. A 1-DW MWr32 unlock commits in the same cycle as beat 2.
- D32 (beat 3): shadow_hi ← trn_rd[63:32].
- D64 (beat 3): shadow_lo ← trn_rd[63:32], shadow_hi ← trn_rd[31:0].
- Address commit happens on the valid EOF beat, one cycle of register latency after it. Byte order: addr[7:0]=lo[31:24], [15:8]=lo[23:16], [23:16]=lo[15:8], [31:24]=lo[7:0]; addr[39:32]=hi[31:24] … [63:56]=hi[7:0]. Then → IDLE.
- If D32/D64 sees a valid beat without EOF (longer than expected), no commit → DRAIN.
- DRAIN: → IDLE on a valid EOF beat.
- Discontinue: trn_rsrc_dsc_n=0 in any state → IDLE next cycle. Shadow and pending unlock are dropped, so a partially received address is never committed.
- Status update per page, evaluated in the same cycle as the commit:
  - Unlock commit → status 1. If status was already 1, pulse unlock_err (status stays 1).
  - Otherwise free=1 → status 0.
  - Unlock wins over a simultaneous free.
- An address write while status=1 still commits; address ownership is the driver's responsibility.

Decomposition:
- Shared package rx_tlp_pkg: FMT_TYPE constants (MWR32 7'h40, MWR64 7'h60, MRD32, MRD64), FSM state encoding, and a byte-swap-DW function reused by the TX engines.
- One natural sub-module: huge_page_status_ctrl. It holds the per-page status bit, the unlock/free priority logic and unlock_err, instantiated NUM_PAGES times.

Test Plan:
- NUM_PAGES=4, MWr64 to BAR2 with dword index 20 (page 2), length 2, payload beat 3 = 64'h0011223344556677 → huge_page_addr[191:128] = 64'h7766554433221100. The other pages are unchanged.
- MWr32, index 18, length 2, beat 2 low = 32'hAABBCCDD, beat 3 high = 32'h01020304 → page 1 addr = 64'h04030201DDCCBBAA.
- Unlock MWr32 at index 25 → status[1] 0→1 one cycle after EOF. A repeat unlock pulses unlock_err once. free[1] with a simultaneous unlock → status stays 1. free alone → status 0.
- Address MWr64 for page 0 with trn_rsrc_dsc_n asserted on beat 3 → addr[63:0] unchanged, FSM in IDLE. An immediately following valid TLP is decoded correctly.
- Address write with length 4 (too long), and a MWr to BAR0 with index 16 → no address or status change. The FSM drains to EOF.
- Throttling (alternating rsrc_rdy_n=1/dst_rdy_n=1 on every beat) on the first scenario → identical result. Asserting reset mid-TLP → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rx_tlp_pkg.sv
// Shared TRN RX definitions: TLP fmt/type codes, receiver FSM encoding and
// the dword byte-swap helper also used by the TX engines.
package rx_tlp_pkg;

  localparam logic [6:0] FMT_MWR32 = 7'h40;
  localparam logic [6:0] FMT_MWR64 = 7'h60;
  localparam logic [6:0] FMT_MRD32 = 7'h00;
  localparam logic [6:0] FMT_MRD64 = 7'h20;

  // Page index wide enough for the largest supported page count (8).
  localparam int PAGE_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H32,
    ST_H64,
    ST_D32,
    ST_D64,
    ST_DRAIN
  } rx_state_e;

  function automatic logic [31:0] bswap_dw(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/huge_page_status_ctrl.sv
// Ownership bit for one huge page: unlock hands the page to hardware, free
// returns it; an unlock of an already-owned page raises a one-cycle error.
module huge_page_status_ctrl (
  input  logic trn_clk,
  input  logic reset,
  input  logic unlock_i,
  input  logic free_i,
  output logic status_o,
  output logic err_o
);

  logic status_q, status_d;
  logic err_q, err_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    status_d = status_q;
    err_d    = 1'b0;
    if (unlock_i) begin
      status_d = 1'b1;
      err_d    = status_q;
    end else if (free_i) begin
      status_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      status_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign status_o = status_q;
  assign err_o    = err_q;

endmodule

// File: rtl/rx_huge_pages_addr_n.sv
// Passive TRN RX snooper: captures per-page 64-bit huge-page bus addresses and
// unlock doorbells from host MWr32/MWr64 TLPs hitting the selected BAR.
module rx_huge_pages_addr_n
  import rx_tlp_pkg::*;
#(
  parameter int NUM_PAGES      = 2,
  parameter int BAR_HIT        = 2,
  parameter int ADDR_BASE_DW   = 16,
  parameter int UNLOCK_BASE_DW = 24
) (
  input  logic                     trn_clk,
  input  logic                     reset,
  input  logic [63:0]              trn_rd,
  input  logic [7:0]               trn_rrem_n,
  input  logic                     trn_rsof_n,
  input  logic                     trn_reof_n,
  input  logic                     trn_rsrc_rdy_n,
  input  logic                     trn_rsrc_dsc_n,
  input  logic [6:0]               trn_rbar_hit_n,
  input  logic                     trn_rdst_rdy_n,
  output logic [64*NUM_PAGES-1:0]  huge_page_addr,
  output logic [NUM_PAGES-1:0]     huge_page_status,
  input  logic [NUM_PAGES-1:0]     huge_page_free,
  output logic                     unlock_err
);

  rx_state_e              state_q, state_d;
  logic                   beat_valid, sof, eof, dsc, bar_hit, in_hdr;
  logic [6:0]             fmt_type;
  logic [5:0]             hdr_index;
  logic [9:0]             len_q;
  logic [31:0]            shadow_lo_q;
  logic                   pend_q;
  logic [PAGE_IDX_W-1:0]  page_q;
  logic                   addr_hit, unl_hit, addr_take, unl_take;
  logic [PAGE_IDX_W-1:0]  addr_page, unl_page, unlock_page;
  logic                   addr_commit, unlock_commit;
  logic [31:0]            commit_lo, commit_hi;
  logic [64*NUM_PAGES-1:0] addr_q;
  logic [NUM_PAGES-1:0]   unlock_vec, err_vec;

  // The remainder is redundant with the TLP length field.
  logic unused_inputs;
  assign unused_inputs = ^{trn_rrem_n, trn_rbar_hit_n};

  assign beat_valid = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof        = beat_valid & ~trn_rsof_n;
  assign eof        = beat_valid & ~trn_reof_n;
  assign dsc        = ~trn_rsrc_dsc_n;
  assign bar_hit    = ~trn_rbar_hit_n[BAR_HIT];
  assign fmt_type   = trn_rd[62:56];
  assign in_hdr     = beat_valid & ((state_q == ST_H32) | (state_q == ST_H64));
  assign hdr_index  = (state_q == ST_H32) ? trn_rd[39:34] : trn_rd[7:2];

  always_comb begin : decode
    addr_hit  = 1'b0;
    unl_hit   = 1'b0;
    addr_page = '0;
    unl_page  = '0;
    for (int k = 0; k < NUM_PAGES; k++) begin
      if ({26'd0, hdr_index} == ADDR_BASE_DW + 2 * k) begin
        addr_hit  = 1'b1;
        addr_page = PAGE_IDX_W'(k);
      end
      if ({26'd0, hdr_index} == UNLOCK_BASE_DW + k) begin
        unl_hit  = 1'b1;
        unl_page = PAGE_IDX_W'(k);
      end
    end
  end

  // An address write ending on its header beat is malformed and ignored.
  assign addr_take = in_hdr & addr_hit & (len_q == 10'd2) & ~eof;
  assign unl_take  = in_hdr & ~addr_take & unl_hit & (len_q != 10'd0);

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    if (dsc) begin
      state_d = ST_IDLE;
    end else if (beat_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sof && bar_hit) begin
            if (fmt_type == FMT_MWR32)      state_d = ST_H32;
            else if (fmt_type == FMT_MWR64) state_d = ST_H64;
            else if (trn_reof_n)            state_d = ST_DRAIN;
          end
        end
        ST_H32, ST_H64: begin
          if (addr_take) state_d = (state_q == ST_H32) ? ST_D32 : ST_D64;
          else           state_d = eof ? ST_IDLE : ST_DRAIN;
        end
        ST_D32, ST_D64, ST_DRAIN: state_d = eof ? ST_IDLE : ST_DRAIN;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin : commit_ctrl
    addr_commit   = 1'b0;
    unlock_commit = 1'b0;
    unlock_page   = page_q;
    commit_lo     = shadow_lo_q;
    commit_hi     = trn_rd[63:32];
    if (state_q == ST_D64) begin
      commit_lo = trn_rd[63:32];
      commit_hi = trn_rd[31:0];
    end
    if (eof && !dsc) begin
      unique case (state_q)
        ST_D32, ST_D64: addr_commit = 1'b1;
        ST_H32, ST_H64: begin
          unlock_commit = unl_take;
          unlock_page   = unl_page;
        end
        ST_DRAIN:       unlock_commit = pend_q;
        default:        ;
      endcase
    end
  end

  // Discontinue drops everything gathered so far for the current TLP.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      shadow_lo_q <= '0;
      pend_q      <= 1'b0;
      page_q      <= '0;
    end else if (dsc) begin
      shadow_lo_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && sof && bar_hit) len_q <= trn_rd[41:32];
      if (state_q == ST_H32 && beat_valid)      shadow_lo_q <= trn_rd[31:0];
      if (addr_take)                            page_q <= addr_page;
      if (unl_take && !eof) begin
        pend_q <= 1'b1;
        page_q <= unl_page;
      end
      if (state_q == ST_DRAIN && eof)           pend_q <= 1'b0;
    end
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (addr_commit) begin
      for (int k = 0; k < NUM_PAGES; k++) begin
        if (page_q == PAGE_IDX_W'(k))
          addr_q[64*k +: 64] <= {bswap_dw(commit_hi), bswap_dw(commit_lo)};
      end
    end
  end

  for (genvar k = 0; k < NUM_PAGES; k++) begin : g_page
    assign unlock_vec[k] = unlock_commit & (unlock_page == PAGE_IDX_W'(k));

    huge_page_status_ctrl u_status (
      .trn_clk  (trn_clk),
      .reset    (reset),
      .unlock_i (unlock_vec[k]),
      .free_i   (huge_page_free[k]),
      .status_o (huge_page_status[k]),
      .err_o    (err_vec[k])
    );
  end

  assign huge_page_addr = addr_q;
  assign unlock_err     = |err_vec;

endmodule

// File: tb/tb_rx_huge_pages_addr_n.sv
// Directed plus randomized TLP stimulus against a page-level reference model.
module tb_rx_huge_pages_addr_n;

  localparam int NP = 4;

  logic             trn_clk = 1'b0;
  logic             reset;
  logic [63:0]      trn_rd;
  logic [7:0]       trn_rrem_n;
  logic             trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
  logic [6:0]       trn_rbar_hit_n;
  logic [64*NP-1:0] huge_page_addr;
  logic [NP-1:0]    huge_page_status;
  logic [NP-1:0]    huge_page_free;
  logic             unlock_err;

  int checks = 0;
  int passed = 0;

  logic [63:0]   exp_addr [NP];
  logic [NP-1:0] exp_status;
  logic          exp_err;
  logic [NP-1:0] free_at_eof;

  rx_huge_pages_addr_n #(.NUM_PAGES(NP)) dut (
    .trn_clk          (trn_clk),
    .reset            (reset),
    .trn_rd           (trn_rd),
    .trn_rrem_n       (trn_rrem_n),
    .trn_rsof_n       (trn_rsof_n),
    .trn_reof_n       (trn_reof_n),
    .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n   (trn_rsrc_dsc_n),
    .trn_rbar_hit_n   (trn_rbar_hit_n),
    .trn_rdst_rdy_n   (trn_rdst_rdy_n),
    .huge_page_addr   (huge_page_addr),
    .huge_page_status (huge_page_status),
    .huge_page_free   (huge_page_free),
    .unlock_err       (unlock_err)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < NP; k++)
      check($sformatf("%s addr%0d", tag, k), huge_page_addr[64*k +: 64], exp_addr[k]);
    check({tag, " status"}, 64'(huge_page_status), 64'(exp_status));
    check({tag, " unlock_err"}, 64'(unlock_err), 64'(exp_err));
  endtask

  task automatic check_all(input string tag);
    @(negedge trn_clk);
    check_outputs(tag);
    exp_err = 1'b0;
  endtask

  task automatic drive_idle();
    trn_rd         = {$urandom, $urandom};
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    trn_rsrc_dsc_n = 1'b1;
    trn_rbar_hit_n = 7'h7f;
    huge_page_free = '0;
  endtask

  // Address bytes arrive in bus order: byte i of the payload stream is address byte i.
  function automatic logic [63:0] model_addr(input logic [31:0] d0, input logic [31:0] d1);
    logic [7:0]  stream [8];
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      stream[i]     = d0[31-8*i -: 8];
      stream[4 + i] = d1[31-8*i -: 8];
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = stream[i];
    return r;
  endfunction

  task automatic model_tlp(input logic [6:0] fmt, input int len, input int idx, input int bar,
                           input bit dropped, input bit eof_seen,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [NP-1:0] free);
    logic [NP-1:0] unl;
    unl     = '0;
    exp_err = 1'b0;
    if (!dropped && bar == 2 && (fmt == 7'h40 || fmt == 7'h60)) begin
      for (int k = 0; k < NP; k++) begin
        if (idx == 16 + 2*k && len == 2) exp_addr[k] = model_addr(d0, d1);
        if (idx == 24 + k && len >= 1)   unl[k] = 1'b1;
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (unl[k]) begin
        if (exp_status[k]) exp_err = 1'b1;
        exp_status[k] = 1'b1;
      end else if (eof_seen && free[k]) begin
        exp_status[k] = 1'b0;
      end
    end
  endtask

  task automatic send_tlp(input logic [6:0] fmt, input int len, input int idx, input int bar,
                          input int dsc_at, input bit throttle,
                          input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] dw [$];
    logic [31:0] a;
    int n_data, n_beats;
    bit dropped;
    n_data = fmt[6] ? len : 0;
    dw.push_back({1'b0, fmt, 14'h0, 10'(len)});
    dw.push_back($urandom);
    if (fmt[5]) dw.push_back($urandom);
    a = $urandom;
    a[7:2] = 6'(idx);
    a[1:0] = 2'b00;
    dw.push_back(a);
    for (int i = 0; i < n_data; i++) dw.push_back(i == 0 ? d0 : (i == 1 ? d1 : $urandom));
    if (dw.size() % 2 != 0) dw.push_back($urandom);
    n_beats = dw.size() / 2;
    dropped = (dsc_at >= 0) && (dsc_at < n_beats);
    for (int b = 0; b < n_beats; b++) begin
      if (throttle) begin
        trn_rd         = {$urandom, $urandom};
        trn_rsof_n     = 1'($urandom);
        trn_reof_n     = 1'($urandom);
        trn_rsrc_rdy_n = (b % 2 == 0);
        trn_rdst_rdy_n = (b % 2 != 0);
        trn_rsrc_dsc_n = 1'b1;
        huge_page_free = '0;
        @(posedge trn_clk); #1;
      end
      trn_rd         = {dw[2*b], dw[2*b + 1]};
      trn_rsof_n     = (b != 0);
      trn_reof_n     = (b != n_beats - 1);
      trn_rsrc_rdy_n = 1'b0;
      trn_rdst_rdy_n = 1'b0;
      trn_rsrc_dsc_n = (b != dsc_at);
      trn_rbar_hit_n = 7'h7f;
      trn_rbar_hit_n[bar] = 1'b0;
      huge_page_free = (b == n_beats - 1) ? free_at_eof : '0;
      @(posedge trn_clk); #1;
      if (b == dsc_at) break;
    end
    drive_idle();
    model_tlp(fmt, len, idx, bar, dropped, (dsc_at < 0) || (dsc_at >= n_beats - 1),
              d0, d1, free_at_eof);
  endtask

  task automatic pulse_free(input logic [NP-1:0] m);
    huge_page_free = m;
    @(posedge trn_clk); #1;
    huge_page_free = '0;
    exp_status = exp_status & ~m;
    exp_err    = 1'b0;
  endtask

  initial begin
    logic [6:0] fmt;
    int len, idx, bar, dsc_at, kind;
    bit thr;

    reset       = 1'b1;
    trn_rrem_n  = '0;
    free_at_eof = '0;
    exp_status  = '0;
    exp_err     = 1'b0;
    for (int k = 0; k < NP; k++) exp_addr[k] = '0;
    drive_idle();
    repeat (3) @(posedge trn_clk);
    @(negedge trn_clk) reset = 1'b0;
    check_outputs("reset");

    send_tlp(7'h60, 2, 20, 2, -1, 1'b0, 32'h00112233, 32'h44556677);
    check_all("mwr64 p2");
    check("mwr64 p2 vector", huge_page_addr[191:128], 64'h7766554433221100);

    send_tlp(7'h40, 2, 18, 2, -1, 1'b0, 32'hAABBCCDD, 32'h01020304);
    check_all("mwr32 p1");
    check("mwr32 p1 vector", huge_page_addr[127:64], 64'h04030201DDCCBBAA);

    send_tlp(7'h40, 1, 25, 2, -1, 1'b0, $urandom, $urandom);
    check_all("unlock p1");
    check("unlock p1 status bit", 64'(huge_page_status[1]), 64'd1);
    send_tlp(7'h40, 1, 25, 2, -1, 1'b0, $urandom, $urandom);
    check_all("repeat unlock");
    check_all("err one cycle");
    free_at_eof = 4'b0010;
    send_tlp(7'h40, 1, 25, 2, -1, 1'b0, $urandom, $urandom);
    free_at_eof = '0;
    check_all("unlock beats free");
    pulse_free(4'b0010);
    check_all("free alone");

    send_tlp(7'h60, 2, 16, 2, 2, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
    check_all("dsc beat3");
    send_tlp(7'h60, 2, 16, 2, 2, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    send_tlp(7'h40, 2, 22, 2, -1, 1'b0, 32'h55AA1234, 32'h0F1E2D3C);
    check_all("dsc then back-to-back");

    send_tlp(7'h40, 4, 16, 2, -1, 1'b0, 32'h11111111, 32'h22222222);
    check_all("too long");
    send_tlp(7'h60, 2, 16, 0, -1, 1'b0, 32'h33333333, 32'h44444444);
    check_all("bar0");
    send_tlp(7'h40, 1, 24, 2, -1, 1'b0, $urandom, $urandom);
    check_all("drain recovered");

    send_tlp(7'h60, 2, 22, 2, -1, 1'b1, 32'h00112233, 32'h44556677);
    check_all("throttled");
    check("throttled vector", huge_page_addr[255:192], 64'h7766554433221100);

    for (int t = 0; t < 40; t++) begin
      kind   = $urandom_range(0, 5);
      fmt    = (kind < 3) ? 7'h40 : ((kind < 5) ? 7'h60 : 7'h00);
      len    = $urandom_range(1, 4);
      idx    = $urandom_range(14, 29);
      bar    = ($urandom_range(0, 3) == 0) ? 0 : 2;
      dsc_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      thr    = 1'($urandom_range(0, 1));
      send_tlp(fmt, len, idx, bar, dsc_at, thr, $urandom, $urandom);
      check_all($sformatf("rand%0d", t));
      if ($urandom_range(0, 3) == 0) begin
        pulse_free(4'($urandom));
        check_all($sformatf("rand%0d free", t));
      end
    end

    send_tlp(7'h40, 1, 24, 2, -1, 1'b0, $urandom, $urandom);
    send_tlp(7'h60, 2, 18, 2, -1, 1'b0, 32'h89ABCDEF, 32'h76543210);
    check_all("pre reset");

    trn_rd         = {1'b0, 7'h60, 14'h0, 10'd2, $urandom};
    trn_rsof_n     = 1'b0;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b0;
    trn_rdst_rdy_n = 1'b0;
    trn_rbar_hit_n = 7'h7b;
    @(posedge trn_clk); #1;
    trn_rd     = {$urandom, 24'h0, 6'd20, 2'b00};
    trn_rsof_n = 1'b1;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NP; k++) exp_addr[k] = '0;
    exp_status = '0;
    exp_err    = 1'b0;
    check_outputs("async reset");
    drive_idle();
    @(posedge trn_clk);
    @(negedge trn_clk) reset = 1'b0;

    send_tlp(7'h60, 2, 20, 2, -1, 1'b0, 32'h00112233, 32'h44556677);
    check_all("after reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
